// File: rtl/stopwatch_display_mux.sv
// Time-multiplexes a frame-consistent snapshot of the stopwatch BCD digits onto a
// 4-digit common-anode 7-segment display as M.SS.T; optional blink via STOPWATCH_DISPLAY_BLINK_EN.
module stopwatch_display_mux #(
  parameter int REFRESH_DIV  = 2500,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Tenths_Seconds,
  input  logic [3:0] Ones_Seconds,
  input  logic [3:0] Tens_Seconds,
  input  logic [3:0] Minutes,
  input  logic       Paused,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int                CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LEN = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      snapshot;   // {Minutes, Tens, Ones, Tenths}
  logic             slot_end;
  logic             frame_end;

  logic [3:0]       digit;
  logic [6:0]       seg_next;
  logic [3:0]       an_next;
  logic             dp_next;
  logic             dark;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'b0111111;
    endcase
  endfunction

  // NOTE: async reset in the sensitivity list; all state uses <= so every
  // register sees pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      idx      <= 2'd0;
      snapshot <= 16'h0000;
    end else begin
      if (slot_end) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      // Capture all four digits at once so a frame never tears mid-rollover.
      if (frame_end)
        snapshot <= {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
    end
  end

`ifdef STOPWATCH_DISPLAY_BLINK_EN
  logic [4:0] frame_cnt;
  logic       paused_snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= 5'd0;
      paused_snap <= 1'b0;
    end else if (frame_end) begin
      frame_cnt   <= frame_cnt + 5'd1;
      paused_snap <= Paused;
    end
  end

  assign dark = paused_snap && frame_cnt[4];
`else
  logic unused_paused;
  assign unused_paused = Paused;
  assign dark          = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0: digit = snapshot[3:0];
      2'd1: digit = snapshot[7:4];
      2'd2: digit = snapshot[11:8];
      2'd3: digit = snapshot[15:12];
      default: digit = 4'd0;
    endcase

    seg_next = bcd_to_seg(digit);
    dp_next  = ~idx[0];            // lit after minutes and after seconds-ones
    an_next  = ~(4'b0001 << idx);
    if (div_cnt < BLANK_LEN || dark)
      an_next = 4'hF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Scoreboard bench for stopwatch_display_mux: stimulus queues expected lit slots,
// a negedge monitor pops one per slot and checks every lit cycle against it.
module tb_stopwatch_display_mux;

  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int LIT_CYCLES   = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S8    = 7'b0000000;
  localparam logic [6:0] SDASH = 7'b0111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tenths, ones, tens, minutes;
  logic       paused;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  slot_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  logic [3:0] prev_an = 4'hF;
  int         lit_run = 0;
  slot_t      cur;

  stopwatch_display_mux #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Tenths_Seconds(tenths),
    .Ones_Seconds  (ones),
    .Tens_Seconds  (tens),
    .Minutes       (minutes),
    .Paused        (paused),
    .seg           (seg),
    .dp            (dp),
    .an            (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the lit slots of one frame, digit order tenths, ones, tens, minutes.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int n_slots);
    slot_t f[4];
    f[0] = '{an: 4'b1110, seg: s0, dp: 1'b1};
    f[1] = '{an: 4'b1101, seg: s1, dp: 1'b0};
    f[2] = '{an: 4'b1011, seg: s2, dp: 1'b1};
    f[3] = '{an: 4'b0111, seg: s3, dp: 1'b0};
    for (int i = 0; i < n_slots; i++) exp_q.push_back(f[i]);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  32'(an),  32'(4'hF));
    check({tag, "_seg"}, 32'(seg), 32'(7'h7F));
    check({tag, "_dp"},  32'(dp),  32'(1'b1));
  endtask

  // Monitor: a slot starts on the first lit cycle after a dark one.
  initial begin
    cur = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        check("one_anode_max", 32'($countones(~an) <= 1), 32'd1);
        if (an !== 4'hF) begin
          if (prev_an === 4'hF) begin
            if (exp_q.size() == 0) begin
              check("unexpected_slot", 32'(exp_q.size()), 32'd1);
              cur = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
            end else begin
              cur = exp_q.pop_front();
            end
            lit_run = 0;
          end
          lit_run++;
          check("slot_an",  32'(an),  32'(cur.an));
          check("slot_seg", 32'(seg), 32'(cur.seg));
          check("slot_dp",  32'(dp),  32'(cur.dp));
        end else if (prev_an !== 4'hF) begin
          check("lit_run", 32'(lit_run), 32'(LIT_CYCLES));
        end
      end
      prev_an = an;
    end
  end

  initial begin
    reset   = 1'b1;
    minutes = 4'd3;
    tens    = 4'd4;
    ones    = 4'd5;
    tenths  = 4'd7;
    paused  = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark("reset_hold");
    end

    #2 reset = 1'b0;
    push_frame(S0, S0, S0, S0, 4);   // snapshot still zero
    push_frame(S7, S5, S4, S3, 4);   // captured at end of first frame

    // Mid-frame change during idx 2: current frame keeps its snapshot.
    wait_neg(25);
    #2 tenths = 4'd8;
    push_frame(S8, S5, S4, S3, 4);

    wait_neg(15);
    #2 minutes = 4'hC;
    push_frame(S8, S5, S4, SDASH, 4);
    push_frame(S8, S5, S4, SDASH, 3); // interrupted by reset in slot 2

    // Land at idx 2 / div_cnt 2, then reset with no clock edge before the check.
    wait_neg(34);
    check("pre_reset_lit_an", 32'(an), 32'(4'b1011));
    #2 reset = 1'b1;
    #1 check_dark("async_reset");

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark("reset_mid");
    end

    #2 reset = 1'b0;
    push_frame(S0, S0, S0, S0, 4);
    push_frame(S8, S5, S4, SDASH, 4);

    wait_neg(33);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
